// File: rtl/dvbc_rs_encoder_if.sv
// Byte-stream bus of the DVB-C RS encoder: randomizer side (in_*), interleaver side (out_*), error pulse.
// The optional bypass strobe exists only when DVBC_RS_BYPASS_EN is defined.
interface dvbc_rs_encoder_if;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_valid;
  logic       out_ready;
  logic       err;
`ifdef DVBC_RS_BYPASS_EN
  logic       bypass;

  modport slave (
    input  in_data, in_sop, in_valid, bypass, out_ready,
    output in_ready, out_data, out_sop, out_eop, out_valid, err
  );
  modport master (
    output in_data, in_sop, in_valid, bypass, out_ready,
    input  in_ready, out_data, out_sop, out_eop, out_valid, err
  );
`else
  modport slave (
    input  in_data, in_sop, in_valid, out_ready,
    output in_ready, out_data, out_sop, out_eop, out_valid, err
  );
  modport master (
    output in_data, in_sop, in_valid, out_ready,
    input  in_ready, out_data, out_sop, out_eop, out_valid, err
  );
`endif
endinterface

// File: rtl/dvbc_rs_encoder.sv
// Systematic RS(K+16,K) encoder over GF(256), polynomial 0x11D, generator roots a^0..a^15.
// Forwards K data bytes then 16 parity bytes through a single output register.
// Build option DVBC_RS_BYPASS_EN: per-packet pass-through selected by bus.bypass at sop.
module dvbc_rs_encoder #(
  parameter int K = 188
) (
  input  logic             clk,
  input  logic             rst_n,
  dvbc_rs_encoder_if.slave bus
);

  localparam int NPAR = 16;
  localparam logic [7:0] LAST_DATA = 8'(K - 1);
  localparam logic [7:0] LAST_PAR  = 8'(NPAR - 1);
  // Generator coefficients, g15 in the top slot down to g0
  localparam logic [NPAR-1:0][7:0] GEN = {
    8'd59, 8'd13, 8'd104, 8'd189, 8'd68, 8'd209, 8'd30, 8'd8,
    8'd163, 8'd65, 8'd41, 8'd229, 8'd98, 8'd50, 8'd36, 8'd59
  };

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

  // Multiply by x modulo 0x11D
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // Shift-and-add product; with a constant first operand this folds to an XOR network
  function automatic logic [7:0] gf_mul(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = c;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NPAR-1:0][7:0]    p_q, p_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;
  logic                    out_valid_q, out_valid_d;
  logic                    err_q, err_d;
  logic                    drop_q, drop_d;
  logic                    run_q, run_d;
  logic                    bypass_q, bypass_d;

  logic                    byp_in;
  logic                    adv;
  logic                    in_ready;
  logic                    accept;
  logic [NPAR-1:0][7:0]    p_base;
  logic [NPAR-1:0][7:0]    p_enc;
  logic [7:0]              fb;
  logic [7:0]              pos;
  logic                    byp;

`ifdef DVBC_RS_BYPASS_EN
  assign byp_in = bus.bypass;
`else
  assign byp_in = 1'b0;
`endif

  // Handshake: the output register advances when empty or being taken; no input during parity
  always_comb begin
    adv      = ~out_valid_q | bus.out_ready;
    in_ready = run_q & (state_q != S_PARITY) & adv;
    accept   = bus.in_valid & in_ready;
  end

  // One LFSR division step; a byte carrying sop always starts from a cleared register
  always_comb begin
    p_base   = bus.in_sop ? '0 : p_q;
    fb       = bus.in_data ^ p_base[NPAR-1];
    p_enc    = '0;
    p_enc[0] = gf_mul(GEN[0], fb);
    for (int i = 1; i < NPAR; i++) begin
      p_enc[i] = p_base[i-1] ^ gf_mul(GEN[i], fb);
    end
  end

  // Next-state: data forwarding, drop/abort handling and parity shift-out
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    drop_d      = drop_q;
    run_d       = 1'b1;
    bypass_d    = bypass_q;
    pos         = bus.in_sop ? 8'd0 : cnt_q;
    byp         = bus.in_sop ? byp_in : bypass_q;

    if (adv) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end

    if (accept) begin
      if (!bus.in_sop && state_q == S_IDLE) begin
        // Stray byte outside a packet: swallow it, flag only the start of the run
        err_d  = ~drop_q;
        drop_d = 1'b1;
      end else begin
        err_d       = bus.in_sop & (state_q == S_DATA);
        drop_d      = 1'b0;
        bypass_d    = byp;
        out_valid_d = 1'b1;
        out_data_d  = bus.in_data;
        out_sop_d   = bus.in_sop;
        out_eop_d   = byp & (pos == LAST_DATA);
        if (!byp) p_d = p_enc;
        if (pos == LAST_DATA) begin
          state_d = byp ? S_IDLE : S_PARITY;
          cnt_d   = 8'd0;
        end else begin
          state_d = S_DATA;
          cnt_d   = pos + 8'd1;
        end
      end
    end else if (state_q == S_PARITY && adv) begin
      out_valid_d = 1'b1;
      out_data_d  = p_q[NPAR-1];
      out_sop_d   = 1'b0;
      out_eop_d   = (cnt_q == LAST_PAR);
      p_d         = {p_q[NPAR-2:0], 8'h00};
      if (cnt_q == LAST_PAR) begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end else begin
        cnt_d   = cnt_q + 8'd1;
      end
    end
  end

  // State and output registers; reset discards any codeword in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      p_q         <= '0;
      out_data_q  <= 8'h00;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      run_q       <= 1'b0;
      bypass_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      run_q       <= run_d;
      bypass_q    <= bypass_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_dvbc_rs_encoder.sv
// Bench for dvbc_rs_encoder: directed packets, expected codewords queued at issue time,
// a negedge monitor pops and compares every output handshake.
// Exercises the bypass path too when DVBC_RS_BYPASS_EN is defined.
module tb_dvbc_rs_encoder;
  localparam int K = 188;
  localparam int N = K + 16;
  localparam logic [7:0] GHAND [16] = '{8'd59, 8'd13, 8'd104, 8'd189, 8'd68, 8'd209, 8'd30, 8'd8,
                                        8'd163, 8'd65, 8'd41, 8'd229, 8'd98, 8'd50, 8'd36, 8'd59};

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dvbc_rs_encoder_if bus();
  dvbc_rs_encoder #(.K(K)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  rec_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         err_cnt = 0;
  int         low_hs = 0;
  int         hs_cnt = 0;
  bit         rand_rdy = 1'b0;
  int         alog [512];
  int         lg [256];
  int         gen [17];
  logic [7:0] pkt [K];
  logic [7:0] pa [K];
  logic [7:0] pb [K];
  logic [7:0] par [16];

  function automatic int gm(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[lg[a] + lg[b]];
  endfunction

  // Field tables and generator polynomial built by explicit multiplication of the 16 root factors
  task automatic build_model();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      alog[i] = x;
      lg[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 285;
    end
    for (int i = 255; i < 512; i++) alog[i] = alog[i-255];
    for (int j = 0; j < 17; j++) gen[j] = 0;
    gen[0] = 1;
    for (int r = 0; r < 16; r++) begin
      for (int j = r + 1; j >= 1; j--) gen[j] = gen[j-1] ^ gm(gen[j], alog[r]);
      gen[0] = gm(gen[0], alog[r]);
    end
  endtask

  // Polynomial long division of pkt(x)*x^16 by the generator; par[0] is the x^15 coefficient
  task automatic model_parity();
    int b [N];
    int c;
    for (int i = 0; i < N; i++) b[i] = (i < K) ? int'(pkt[i]) : 0;
    for (int i = 0; i < K; i++) begin
      c = b[i];
      if (c != 0) begin
        for (int j = 1; j <= 16; j++) b[i+j] = b[i+j] ^ gm(c, gen[16-j]);
      end
    end
    for (int j = 0; j < 16; j++) par[j] = 8'(b[K+j]);
  endtask

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic push_data(input int n, input bit eop_last);
    for (int i = 0; i < n; i++) exp_q.push_back({pkt[i], i == 0, eop_last && (i == n - 1)});
  endtask

  task automatic push_parity();
    for (int j = 0; j < 16; j++) exp_q.push_back({par[j], 1'b0, j == 15});
  endtask

  task automatic push_codeword();
    push_data(K, 1'b0);
    model_parity();
    push_parity();
  endtask

  task automatic rand_pkt();
    for (int i = 0; i < K; i++) pkt[i] = 8'($urandom_range(0, 255));
  endtask

  // Present one byte and hold it until the encoder takes it (bounded)
  task automatic send_byte(input logic [7:0] d, input logic s);
    bit acc;
    int guard;
    bus.in_data  = d;
    bus.in_sop   = s;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 4000) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no in_ready, required accept of byte %02h", d);
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(pkt[i], i == 0);
  endtask

  task automatic wait_drain(input int budget);
    int guard;
    bus.in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < budget) begin
      @(posedge clk);
      guard++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  // Output ready: always high, or a fresh coin flip each cycle
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every output handshake is compared against the queue head
  always @(negedge clk) begin
    rec_t e;
    rec_t g;
    if (bus.err) err_cnt++;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      g = {bus.out_data, bus.out_sop, bus.out_eop};
      if (!bus.in_ready) low_hs++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got data=%02h sop=%0d eop=%0d, required no output",
                 g.d, g.sop, g.eop);
      end else begin
        e = exp_q.pop_front();
        if (g != e)begin
          bad++;
          $display("FAIL out_byte#%0d: got data=%02h sop=%0d eop=%0d, required data=%02h sop=%0d eop=%0d",
                   hs_cnt, g.d, g.sop, g.eop, e.d, e.sop, e.eop);
        end
      end
      hs_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, h0, l0;
    build_model();
    rst_n        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_sop   = 1'b0;
    bus.in_valid = 1'b0;
`ifdef DVBC_RS_BYPASS_EN
    bus.bypass   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sop", bus.out_sop, 0);
    check("rst_out_eop", bus.out_eop, 0);
    check("rst_err", bus.err, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1;
    check("rel_in_ready_after_edge", bus.in_ready, 1);

    // All-zero packet: parity all zero, 1-cycle latency on byte 0
    for (int i = 0; i < K; i++) pkt[i] = 8'h00;
    push_data(K, 1'b0);
    for (int j = 0; j < 16; j++) par[j] = 8'h00;
    push_parity();
    send_byte(pkt[0], 1'b1);
    check("lat_out_valid", bus.out_valid, 1);
    check("lat_out_sop", bus.out_sop, 1);
    send_range(1, K);
    wait_drain(1000);

    // Single 0x01 in the last data byte: parity is the generator coefficients g15..g0
    pkt[K-1] = 8'h01;
    push_data(K, 1'b0);
    for (int j = 0; j < 16; j++) par[j] = GHAND[j];
    push_parity();
    send_range(0, K);
    wait_drain(1000);

    // Sync byte followed by zeros
    for (int i = 0; i < K; i++) pkt[i] = 8'h00;
    pkt[0] = 8'h47;
    push_codeword();
    send_range(0, K);
    wait_drain(1000);

    // Linearity: A, B and A^B each encoded
    rand_pkt();
    pa = pkt;
    push_codeword();
    send_range(0, K);
    wait_drain(1000);
    rand_pkt();
    pb = pkt;
    push_codeword();
    send_range(0, K);
    wait_drain(1000);
    for (int i = 0; i < K; i++) pkt[i] = pa[i] ^ pb[i];
    push_codeword();
    send_range(0, K);
    wait_drain(1000);

    // Abort: sop re-asserted at byte 100 restarts encoding from a cleared register
    e0 = err_cnt;
    rand_pkt();
    push_data(100, 1'b0);
    send_range(0, 100);
    check("abort_err_before", bus.err, 0);
    rand_pkt();
    push_codeword();
    send_byte(pkt[0], 1'b1);
    check("abort_err_pulse", bus.err, 1);
    send_range(1, K);
    wait_drain(1000);
    check("abort_err_count", err_cnt - e0, 1);

    // Stray bytes in IDLE: dropped, one err pulse for the run, no output
    e0 = err_cnt;
    h0 = hs_cnt;
    send_byte(8'h11, 1'b0);
    check("drop1_err", bus.err, 1);
    check("drop1_out_valid", bus.out_valid, 0);
    send_byte(8'h22, 1'b0);
    check("drop2_err", bus.err, 0);
    check("drop2_out_valid", bus.out_valid, 0);
    send_byte(8'h33, 1'b0);
    check("drop3_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("drop_err_count", err_cnt - e0, 1);
    check("drop_handshakes", hs_cnt - h0, 0);
    rand_pkt();
    push_codeword();
    send_range(0, K);
    wait_drain(1000);

    // Ten back-to-back packets under random out_ready
    rand_rdy = 1'b1;
    l0 = low_hs;
    for (int p = 0; p < 10; p++) begin
      rand_pkt();
      push_codeword();
      send_range(0, K);
    end
    wait_drain(20000);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_low_handshakes", low_hs - l0, 160);

    // Reset while parity byte 5 is on the output
    rand_pkt();
    push_codeword();
    send_range(0, K);
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("par5_on_output", bus.out_data, par[5]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    check("mid_rst_out_eop", bus.out_eop, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_left", exp_q.size(), 11);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_in_ready", bus.in_ready, 1);
    rand_pkt();
    push_codeword();
    send_range(0, K);
    wait_drain(1000);

`ifdef DVBC_RS_BYPASS_EN
    // Bypass packet: K bytes, eop on the last data byte, then a normal packet
    bus.bypass = 1'b1;
    rand_pkt();
    push_data(K, 1'b1);
    send_byte(pkt[0], 1'b1);
    bus.bypass = 1'b0;
    send_range(1, K);
    wait_drain(1000);
    rand_pkt();
    push_codeword();
    send_range(0, K);
    wait_drain(1000);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dvbc_rs_encoder.md
# dvbc_rs_encoder

Systematic Reed-Solomon RS(204,188, t=8) encoder for the DVB-C modulator chain. It sits directly downstream of the energy-dispersal randomizer and consumes its 188-byte randomized packets. For each packet it emits the 188 data bytes unchanged, followed by 16 parity bytes, as a 204-byte codeword. Its output feeds the convolutional interleaver.

## Interface
- `K`, 188, data bytes per codeword; the codeword is K+16 bytes; legal range 1..239 (shortened RS(255,239)).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  8  randomized byte from the randomizer.
- `in_sop`  in  1  marks the first byte of a packet; qualified by `in_valid`.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  encoder accepts a byte this cycle.
- `out_data`  out  8  codeword byte.
- `out_sop`  out  1  first byte of codeword.
- `out_eop`  out  1  last byte of codeword (parity byte 15).
- `out_valid`  out  1  output byte valid.
- `out_ready`  in  1  downstream accepts the output byte.
- `err`  out  1  one-cycle pulse on a protocol error.

## Operation
- Field GF(256), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), λ=0x02.
- Generator g(x)=(x+λ^0)(x+λ^1)…(x+λ^15).
- Coefficients g0..g15 are constants, implemented as constant-multiplier XOR networks (no tables).
- Parity register p[0..15], 8 bits each. On each accepted data byte:
  - fb = in_data ^ p[15]
  - p[i] = p[i-1] ^ g_i·fb for i = 15..1
  - p[0] = g_0·fb
- State machine:
  - IDLE: waits for an accepted byte with `in_sop`=1. That byte is byte 0: clear p (the byte is encoded against p=0), go to DATA with cnt=1.
  - DATA: each accepted byte is encoded and forwarded, cnt++. After byte K-1 is accepted, go to PARITY with cnt=0.
  - PARITY: each output handshake emits p[15] and shifts p[i]=p[i-1], p[0]=0. After parity byte 15 (with `out_eop`) is emitted, go to IDLE.
- Bytes accepted in IDLE without `in_sop` are dropped with `in_ready`=1, so the upstream does not stall. `err` pulses once per dropped run.
- `in_sop` accepted in DATA with cnt≠0 aborts the current codeword:
  - pulse `err`
  - clear p, encode the byte as the new byte 0, cnt=1
  - already-forwarded bytes of the aborted packet are not recalled, and no parity or `out_eop` is emitted for them.
- `in_ready` = (state≠PARITY) & (~out_valid | out_ready).

## Timing
- A single output register stage. A byte accepted at edge n appears on `out_data` after edge n (1-cycle latency) and holds until `out_valid & out_ready`.
- Parity bytes are generated from the output-register path, so parity byte 0 follows data byte K-1 with no bubble when `out_ready`=1.
- Full-rate throughput is 204 output cycles per 188 input bytes; `in_ready` is low for exactly 16 handshake cycles per codeword.
- While `out_ready`=0, all state holds and `out_*` are stable.
- Reset values: `in_ready`=0 during reset and 1 from the first edge after deassertion. `out_data`=0, `out_sop`=0, `out_eop`=0, `out_valid`=0, `err`=0, state=IDLE, cnt=0, p=0.
- Reset asserted mid-codeword discards the codeword immediately; there is no partial parity output.

## Configuration
- `DVBC_RS_BYPASS_EN` defined:
  - adds input port `bypass` (1 bit), sampled only when a byte with `in_sop` is accepted and held for that packet.
  - With `bypass`=1 the packet passes as K bytes; `out_eop` is on byte K-1, there is no PARITY state, and p is not updated.
- Not defined: no `bypass` port; every packet is encoded.

## Test plan
- All-zero 188-byte packet, `out_ready`=1 → 204 output bytes, bytes 188..203 all 0x00, `out_sop` on byte 0, `out_eop` on byte 203, latency 1 cycle.
- Packet with byte 187=0x01 and all others 0x00 → parity bytes 0..15 equal g15..g0 of the generator. Packet 0x47,0x00…0x00 and a random packet → parity matches a bit-exact C/Python RS(204,188) model. Check linearity: parity(A^B) = parity(A)^parity(B).
- Random `out_ready` (50% duty) over 10 back-to-back random packets → output identical to the `out_ready`=1 run, no byte loss or duplication, `in_ready` low exactly 16 handshakes per packet.
- `in_sop` re-asserted at byte 100 → `err` pulses one cycle, the new packet is encoded from p=0 and its parity matches the model. Bytes without `in_sop` in IDLE → dropped, `err` pulse, no `out_valid`.
- Assert `rst_n`=0 at parity byte 5 → outputs take reset values asynchronously; the next packet after release encodes correctly.
- With `DVBC_RS_BYPASS_EN` and `bypass`=1 → 188 bytes out, `out_eop` on byte 187; the next packet with `bypass`=0 is encoded to 204 bytes with correct parity.
